adder_tree_sched: RTL and testbench

Sequencing controller for the shared `adder_tree` row adder in the convolution datapath. Each of the KERNEL_SIZE PE rows presents its KERNEL_SIZE products through a valid/ready channel. The scheduler issues the rows to the single adder tree in fixed order (row 0 to row K-1), tracks results through the adder's fixed pipeline, and accumulates the K row sums into one window sum. Window sums are delivered on a valid/ready output, and a run of `cfg_num_windows` windows is framed by `cfg_start` and `done`.

---
 rtl/conv_pkg.sv | 41 ++++
 rtl/adder_tree_sched_if.sv | 39 +++
 rtl/sched_tag_pipe.sv | 36 +++
 rtl/adder_tree_sched.sv | 172 +++++++++++++++++
 tb/tb_adder_tree_sched.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution row-adder scheduler.
package conv_pkg;

    localparam int unsigned DEF_KERNEL_SIZE   = 3;
    localparam int unsigned DEF_DATA_WIDTH    = 8;
    localparam int unsigned DEF_WEIGHT_WIDTH  = 8;
    localparam int unsigned DEF_ADDER_LATENCY = 3;
    localparam int unsigned DEF_CNT_WIDTH     = 16;

    // Product width, adder-tree result width, window-sum width
    function automatic int unsigned calc_pw(input int unsigned dw, input int unsigned ww);
        return dw + ww;
    endfunction

    function automatic int unsigned calc_aw(input int unsigned pw, input int unsigned k);
        return pw + k;
    endfunction

    function automatic int unsigned calc_ow(input int unsigned aw, input int unsigned k);
        return aw + $clog2(k);
    endfunction

    localparam int unsigned PW = calc_pw(DEF_DATA_WIDTH, DEF_WEIGHT_WIDTH);
    localparam int unsigned AW = calc_aw(PW, DEF_KERNEL_SIZE);
    localparam int unsigned OW = calc_ow(AW, DEF_KERNEL_SIZE);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_HOLD_LAST = 2'd2,
        S_DRAIN     = 2'd3
    } sched_state_t;

    // Travels alongside an issued row through the adder latency
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } sched_tag_t;

endpackage

// File: rtl/adder_tree_sched_if.sv
// Row, adder-tree, output and run-control signals of the scheduler.
interface adder_tree_sched_if #(
    parameter int unsigned KERNEL_SIZE  = conv_pkg::DEF_KERNEL_SIZE,
    parameter int unsigned DATA_WIDTH   = conv_pkg::DEF_DATA_WIDTH,
    parameter int unsigned WEIGHT_WIDTH = conv_pkg::DEF_WEIGHT_WIDTH,
    parameter int unsigned CNT_WIDTH    = conv_pkg::DEF_CNT_WIDTH
) ();
    localparam int unsigned PROD_W = conv_pkg::calc_pw(DATA_WIDTH, WEIGHT_WIDTH);
    localparam int unsigned SUM_W  = conv_pkg::calc_aw(PROD_W, KERNEL_SIZE);
    localparam int unsigned OUT_W  = conv_pkg::calc_ow(SUM_W, KERNEL_SIZE);
    localparam int unsigned ROW_W  = KERNEL_SIZE * PROD_W;

    logic                               cfg_start;
    logic [CNT_WIDTH-1:0]               cfg_num_windows;
    logic [KERNEL_SIZE-1:0]             row_valid;
    logic [KERNEL_SIZE*ROW_W-1:0]       row_data;
    logic [KERNEL_SIZE-1:0]             row_ready;
    logic                               adder_en;
    logic [ROW_W-1:0]                   adder_dataIn;
    logic [SUM_W-1:0]                   adder_dataOut;
    logic                               out_valid;
    logic [OUT_W-1:0]                   out_data;
    logic                               out_ready;
    logic                               busy;
    logic                               done;

    // Scheduler side
    modport master (
        input  cfg_start, cfg_num_windows, row_valid, row_data, adder_dataOut, out_ready,
        output row_ready, adder_en, adder_dataIn, out_valid, out_data, busy, done
    );

    // Environment side: PE rows, adder tree, downstream and controller
    modport slave (
        output cfg_start, cfg_num_windows, row_valid, row_data, adder_dataOut, out_ready,
        input  row_ready, adder_en, adder_dataIn, out_valid, out_data, busy, done
    );

endinterface

// File: rtl/sched_tag_pipe.sv
// Tag shift register matching the adder-tree latency, with synchronous clear.
module sched_tag_pipe
    import conv_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_ADDER_LATENCY
) (
    input  logic       clk,
    input  logic       i_clr,
    input  sched_tag_t i_tag,
    output sched_tag_t o_tag,
    output logic       o_last_inflight_c
);

    sched_tag_t r_stage [DEPTH];

    // Shift one stage per cycle; clear drops every in-flight tag
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_tag = r_stage[DEPTH-1];

    // Any window-closing row still inside the adder
    always_comb begin
        o_last_inflight_c = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_stage[i].valid && r_stage[i].last) o_last_inflight_c = 1'b1;
        end
    end

endmodule

// File: rtl/adder_tree_sched.sv
// Issues K PE rows per window to the shared adder tree, accumulates the row
// sums into a window sum and hands it downstream. Optional macro
// SCHED_SAT_EN clamps the delivered sum to the pixel range.
module adder_tree_sched
    import conv_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE   = DEF_KERNEL_SIZE,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned WEIGHT_WIDTH  = DEF_WEIGHT_WIDTH,
    parameter int unsigned ADDER_LATENCY = DEF_ADDER_LATENCY,
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    adder_tree_sched_if.master bus
);

    localparam int unsigned K         = KERNEL_SIZE;
    localparam int unsigned PROD_W    = calc_pw(DATA_WIDTH, WEIGHT_WIDTH);
    localparam int unsigned SUM_W     = calc_aw(PROD_W, K);
    localparam int unsigned OUT_W     = calc_ow(SUM_W, K);
    localparam int unsigned ROW_W     = K * PROD_W;
    localparam int unsigned ROW_IDX_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(K - 1);

    sched_state_t           r_state;
    logic [ROW_IDX_W-1:0]   r_row;
    logic [CNT_WIDTH-1:0]   r_num_windows;
    logic [CNT_WIDTH-1:0]   r_issued_cnt;
    logic [CNT_WIDTH-1:0]   r_done_cnt;
    logic [OUT_W-1:0]       r_acc;
    logic [OUT_W-1:0]       r_out_data;
    logic                   r_out_valid;
    logic                   r_busy;
    logic                   r_done;

    logic                   w_is_last_row;
    logic                   w_last_inflight;
    logic                   w_path_clear;
    logic                   w_grant;
    logic                   w_last_window;
    logic [ROW_W-1:0]       w_row_slice;
    sched_tag_t             w_tag_in;
    sched_tag_t             w_tag_out;
    logic [OUT_W-1:0]       w_sum_ext;
    logic [OUT_W-1:0]       w_last_sum;
    logic [OUT_W-1:0]       w_out_load;

    // Grant the current row; the closing row waits for a clear output path
    always_comb begin
        w_is_last_row = (r_row == LAST_ROW);
        w_path_clear  = !r_out_valid && !w_last_inflight;
        w_row_slice   = bus.row_data[int'(r_row) * ROW_W +: ROW_W];
        w_grant       = 1'b0;
        if ((r_state == S_ISSUE || r_state == S_HOLD_LAST) && bus.row_valid[r_row]) begin
            w_grant = !w_is_last_row || w_path_clear;
        end
        w_last_window  = (r_issued_cnt + CNT_WIDTH'(1)) == r_num_windows;
        w_tag_in.valid = w_grant;
        w_tag_in.first = w_grant && (r_row == '0);
        w_tag_in.last  = w_grant && w_is_last_row;
    end

    assign bus.row_ready    = w_grant ? (K'(1) << r_row) : '0;
    assign bus.adder_en     = w_grant;
    assign bus.adder_dataIn = w_grant ? w_row_slice : '0;

    sched_tag_pipe #(
        .DEPTH (ADDER_LATENCY)
    ) u_tag_pipe (
        .clk               (clk),
        .i_clr             (rst),
        .i_tag             (w_tag_in),
        .o_tag             (w_tag_out),
        .o_last_inflight_c (w_last_inflight)
    );

    // Window sum as it leaves the accumulator; a single-row window skips acc
    assign w_sum_ext  = OUT_W'(bus.adder_dataOut);
    assign w_last_sum = w_tag_out.first ? w_sum_ext : (r_acc + w_sum_ext);

`ifdef SCHED_SAT_EN
    localparam logic [OUT_W-1:0] SAT_MAX = OUT_W'((64'd1 << DATA_WIDTH) - 64'd1);
    assign w_out_load = (w_last_sum > SAT_MAX) ? SAT_MAX : w_last_sum;
`else
    assign w_out_load = w_last_sum;
`endif

    // Run-control FSM with row issue, result capture and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_row         <= '0;
            r_num_windows <= '0;
            r_issued_cnt  <= '0;
            r_done_cnt    <= '0;
            r_acc         <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_done_cnt  <= r_done_cnt + CNT_WIDTH'(1);
            end

            if (w_tag_out.valid) begin
                if (w_tag_out.last) begin
                    r_out_data  <= w_out_load;
                    r_out_valid <= 1'b1;
                end else if (w_tag_out.first) begin
                    r_acc <= w_sum_ext;
                end else begin
                    r_acc <= r_acc + w_sum_ext;
                end
            end

            if (w_grant) begin
                if (w_is_last_row) begin
                    r_row        <= '0;
                    r_issued_cnt <= r_issued_cnt + CNT_WIDTH'(1);
                end else begin
                    r_row <= r_row + ROW_IDX_W'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_start) begin
                        r_num_windows <= bus.cfg_num_windows;
                        r_row         <= '0;
                        r_issued_cnt  <= '0;
                        r_done_cnt    <= '0;
                        if (bus.cfg_num_windows == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                // HOLD_LAST behaves like ISSUE parked on the closing row
                S_ISSUE, S_HOLD_LAST: begin
                    if (w_grant && w_is_last_row && w_last_window) begin
                        r_state <= S_DRAIN;
                    end else if (w_is_last_row && !w_path_clear) begin
                        r_state <= S_HOLD_LAST;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_DRAIN: begin
                    if (r_done_cnt == r_num_windows) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed-sequence bench with randomized data/handshakes for adder_tree_sched.
module tb_adder_tree_sched;
    import conv_pkg::*;

    localparam int K     = int'(DEF_KERNEL_SIZE);
    localparam int L     = int'(DEF_ADDER_LATENCY);
    localparam int CW    = int'(DEF_CNT_WIDTH);
    localparam int ROW_W = K * int'(PW);
    localparam int MAXW  = 16;
`ifdef SCHED_SAT_EN
    localparam logic [63:0] BASIC_EXP = 64'd255;
`else
    localparam logic [63:0] BASIC_EXP = 64'd366;
`endif
    localparam int DIR_PROD [K*K] = '{1, 2, 3, 10, 20, 30, 100, 100, 100};

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [63:0]        last_out;
    logic [K*ROW_W-1:0] win_data [MAXW];
    logic [OW-1:0]      exp_out  [MAXW];
    logic [AW-1:0]      add_pipe [L];

    adder_tree_sched_if #(
        .KERNEL_SIZE (DEF_KERNEL_SIZE), .DATA_WIDTH (DEF_DATA_WIDTH),
        .WEIGHT_WIDTH (DEF_WEIGHT_WIDTH), .CNT_WIDTH (DEF_CNT_WIDTH)
    ) bus ();

    adder_tree_sched #(
        .KERNEL_SIZE (DEF_KERNEL_SIZE), .DATA_WIDTH (DEF_DATA_WIDTH),
        .WEIGHT_WIDTH (DEF_WEIGHT_WIDTH), .ADDER_LATENCY (DEF_ADDER_LATENCY),
        .CNT_WIDTH (DEF_CNT_WIDTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [AW-1:0] row_sum(input logic [ROW_W-1:0] d);
        logic [AW-1:0] s = '0;
        for (int k = 0; k < K; k++) s = s + AW'(d[k*int'(PW) +: PW]);
        return s;
    endfunction

    // Adder tree: sum of the issued row appears ADDER_LATENCY cycles later
    always_ff @(posedge clk) begin
        add_pipe[0] <= bus.adder_en ? row_sum(bus.adder_dataIn) : '0;
        for (int i = 1; i < L; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign bus.adder_dataOut = add_pipe[L-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Window w: K rows of K products; expected output = plain sum (clamped if enabled)
    task automatic build_window(input int w, input bit rnd);
        longint s = 0;
        int     p;
        for (int r = 0; r < K; r++) begin
            for (int k = 0; k < K; k++) begin
                p = rnd ? int'($urandom_range(0, 65535)) : DIR_PROD[r*K + k];
                win_data[w][r*ROW_W + k*int'(PW) +: PW] = PW'(p);
                s += longint'(p);
            end
        end
`ifdef SCHED_SAT_EN
        if (s > longint'((1 << DEF_DATA_WIDTH) - 1)) s = longint'((1 << DEF_DATA_WIDTH) - 1);
`endif
        exp_out[w] = OW'(s);
    endtask

    task automatic check_reset_values();
        chk("rst_row_ready", 64'(bus.row_ready), 64'd0);
        chk("rst_adder_en", 64'(bus.adder_en), 64'd0);
        chk("rst_adder_dataIn", 64'(bus.adder_dataIn), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
    endtask

    // ready_mode: 0 always, 1 blocked cycles 5..24, 2 random
    // valid_mode: 0 always, 1 row1 stalled cycles 1..5, 2 random
    task automatic run_test(input int n, input bit rnd, input int ready_mode,
                            input int valid_mode, input bit poke);
        int gcount = 0, accepted = 0, t_last = -100, rise_cyc = -1;
        int earliest = (n == 0) ? 0 : -1;
        int deadline = (n == 0) ? 0 : -1;
        int idx, exp_row;
        bit m_ov = 0, m_grant, vld, done_seen = 0;
        for (int w = 0; w < n; w++) build_window(w, rnd);
        @(negedge clk);
        bus.cfg_start = 1'b1; bus.cfg_num_windows = CW'(n);
        bus.row_valid = '0;  bus.out_ready = 1'b0;
        for (int i = 0; i < 600 && !done_seen; i++) begin
            @(negedge clk);
            bus.cfg_start = poke && (i == 2);
            bus.cfg_num_windows = poke ? CW'(1) : CW'(n);
            for (int r = 0; r < K; r++) begin
                idx = gcount / K + ((r < gcount % K) ? 1 : 0);
                case (valid_mode)
                    1:       vld = !(r == 1 && i >= 1 && i < 6);
                    2:       vld = ($urandom_range(0, 3) != 0);
                    default: vld = 1'b1;
                endcase
                bus.row_valid[r] = (idx < n) && vld;
                bus.row_data[r*ROW_W +: ROW_W] = (idx < n) ? win_data[idx][r*ROW_W +: ROW_W] : '0;
            end
            case (ready_mode)
                1:       bus.out_ready = !(i >= 5 && i < 25);
                2:       bus.out_ready = ($urandom_range(0, 9) < 7);
                default: bus.out_ready = 1'b1;
            endcase
            #1;
            if (i == rise_cyc) m_ov = 1'b1;
            exp_row = gcount % K;
            m_grant = (gcount < n*K) && bus.row_valid[exp_row] &&
                      (exp_row != K-1 || (!m_ov && i > t_last + L));
            chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
            chk("adder_en", 64'(bus.adder_en), 64'(m_grant));
            if (m_grant) begin
                chk("row_ready", 64'(bus.row_ready), 64'd1 << exp_row);
                chk("adder_dataIn", 64'(bus.adder_dataIn),
                    64'(win_data[gcount / K][exp_row*ROW_W +: ROW_W]));
                if (exp_row == K-1) begin
                    t_last   = i;
                    rise_cyc = i + L + 1;
                end
                gcount++;
            end else begin
                chk("row_ready_idle", 64'(bus.row_ready), 64'd0);
            end
            if (m_ov && bus.out_ready) begin
                chk("out_data", 64'(bus.out_data), 64'(exp_out[accepted]));
                last_out = 64'(bus.out_data);
                accepted++;
                m_ov = 1'b0;
                if (accepted == n) begin
                    earliest = i + 1;
                    deadline = i + 2;
                end
            end
            if (earliest < 0 || i < earliest) begin
                chk("done_early", 64'(bus.done), 64'd0);
                if (n > 0) chk("busy_run", 64'(bus.busy), 64'd1);
            end else if (bus.done === 1'b1) begin
                done_seen = 1'b1;
                chk("busy_at_done", 64'(bus.busy), 64'd0);
            end else if (i >= deadline) begin
                chk("done_late", 64'(bus.done), 64'd1);
                done_seen = 1'b1;
            end
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $error("FAIL run_timeout observed=no_done expected=done n=%0d", n);
        end
        @(negedge clk);
        bus.row_valid = '0;
        #1;
        chk("done_pulse_width", 64'(bus.done), 64'd0);
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        chk("adder_en_idle", 64'(bus.adder_en), 64'd0);
        chk("out_count", 64'(accepted), 64'(n));
    endtask

    task automatic reset_test();
        build_window(0, 1'b1);
        @(negedge clk);
        bus.cfg_start = 1'b1; bus.cfg_num_windows = CW'(2);
        bus.row_valid = '1;   bus.row_data = win_data[0]; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.cfg_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("post_rst_adder_en", 64'(bus.adder_en), 64'd0);
            chk("post_rst_busy", 64'(bus.busy), 64'd0);
        end
        bus.row_valid = '0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        last_out = '0;
        bus.cfg_start = 1'b0; bus.cfg_num_windows = '0;
        bus.row_valid = '0;   bus.row_data = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;

        run_test(1, 1'b0, 0, 0, 1'b0);
        chk("basic_sum", last_out, BASIC_EXP);
        run_test(1, 1'b0, 0, 1, 1'b0);
        chk("stall_sum", last_out, BASIC_EXP);
        run_test(4, 1'b1, 0, 0, 1'b1);
        run_test(2, 1'b1, 1, 0, 1'b0);
        run_test(0, 1'b1, 0, 0, 1'b0);
        run_test(8, 1'b1, 2, 2, 1'b0);
        reset_test();
        run_test(2, 1'b1, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
